// File: rtl/switch_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : switch_event_arbiter
// Description : Turns debounced switch levels into press/release events.
//               Each switch owns a one-deep pending slot; a round-robin
//               arbiter shares one valid/ready event channel among them.
//               Edges arriving while a slot is still occupied are dropped
//               and flagged in a sticky per-switch lost bit.
// Ports       : i_Clk, i_Reset (sync, active-high)
//               i_Switch      - debounced levels, synchronous to i_Clk
//               o_Event_Valid / i_Event_Ready - event handshake
//               o_Event_Index - switch number of the presented event
//               o_Event_Press - 1 = press (rising), 0 = release (falling)
//               o_Lost        - sticky "edge dropped" flags
//               i_Lost_Clear  - clears all o_Lost bits
// Revision    : 1.0 - initial release
// ============================================================================
module switch_event_arbiter #(
    parameter int NUM_SWITCHES = 4,
    parameter int IDX_W        = 2
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    output logic                    o_Event_Valid,
    input  logic                    i_Event_Ready,
    output logic [IDX_W-1:0]        o_Event_Index,
    output logic                    o_Event_Press,
    output logic [NUM_SWITCHES-1:0] o_Lost,
    input  logic                    i_Lost_Clear
);

    logic [NUM_SWITCHES-1:0] prev;
    logic [NUM_SWITCHES-1:0] pend;
    logic [NUM_SWITCHES-1:0] ptype;
    logic [IDX_W-1:0]        ptr;

    logic [NUM_SWITCHES-1:0] rise;
    logic [NUM_SWITCHES-1:0] fall;
    logic [NUM_SWITCHES-1:0] sw_edge;
    logic [NUM_SWITCHES-1:0] gnt_oh;
    logic [NUM_SWITCHES-1:0] drop;
    logic [NUM_SWITCHES-1:0] accept;
    logic                    out_free;
    logic                    found;
    logic                    grant;
    logic [IDX_W-1:0]        grant_idx;
    int                      cand;

    assign rise     = i_Switch & ~prev;
    assign fall     = ~i_Switch & prev;
    assign sw_edge  = rise | fall;
    assign out_free = ~o_Event_Valid | i_Event_Ready;
    assign grant    = out_free & found;

    // Round-robin search: first pending slot at or after ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int j = 0; j < NUM_SWITCHES; j++) begin
            cand = int'(ptr) + j;
            if (cand >= NUM_SWITCHES) begin
                cand = cand - NUM_SWITCHES;
            end
            if (!found && pend[cand[IDX_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NUM_SWITCHES; i++) begin
            gnt_oh[i] = grant && (grant_idx == IDX_W'(i));
        end
    end

    // A slot being granted this cycle is free for a new edge in the same cycle.
    assign drop   = sw_edge & pend & ~gnt_oh;
    assign accept = sw_edge & ~drop;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            // Sampling the live level means a switch held through reset
            // produces no spurious edge afterwards.
            prev          <= i_Switch;
            pend          <= '0;
            ptype         <= '0;
            ptr           <= '0;
            o_Event_Valid <= 1'b0;
            o_Event_Index <= '0;
            o_Event_Press <= 1'b0;
            o_Lost        <= '0;
        end else begin
            prev   <= i_Switch;
            pend   <= accept | (pend & ~gnt_oh);
            ptype  <= (accept & rise) | (~accept & ptype);
            // A drop in the clearing cycle still sets its bit.
            o_Lost <= (i_Lost_Clear ? '0 : o_Lost) | drop;

            if (out_free) begin
                if (found) begin
                    o_Event_Valid <= 1'b1;
                    o_Event_Index <= grant_idx;
                    o_Event_Press <= ptype[grant_idx];
                    ptr           <= (grant_idx == IDX_W'(NUM_SWITCHES - 1))
                                     ? '0 : grant_idx + 1'b1;
                end else begin
                    o_Event_Valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_event_arbiter
// Description : Self-checking bench for switch_event_arbiter. A per-cycle
//               behavioural model (slot arrays, modulo round-robin search)
//               predicts the event channel and lost flags; directed
//               scenarios are followed by a long randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_event_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] sw;
    logic         rdy;
    logic         clr;
    logic         valid;
    logic [W-1:0] idx;
    logic         press;
    logic [N-1:0] lost;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           m_prev [N];
    bit           m_slot [N];
    bit           m_type [N];
    bit           m_valid;
    int           m_idx;
    bit           m_press;
    bit [N-1:0]   m_lost;
    int           m_ptr;

    switch_event_arbiter #(
        .NUM_SWITCHES (N),
        .IDX_W        (W)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Switch      (sw),
        .o_Event_Valid (valid),
        .i_Event_Ready (rdy),
        .o_Event_Index (idx),
        .o_Event_Press (press),
        .o_Lost        (lost),
        .i_Lost_Clear  (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the specified behaviour, computed from the rules directly.
    task automatic model_step();
        bit free;
        int win;
        bit wtype;
        bit [N-1:0] nlost;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = sw[i];
                m_slot[i] = 1'b0;
                m_type[i] = 1'b0;
            end
            m_valid = 1'b0;
            m_idx   = 0;
            m_press = 1'b0;
            m_lost  = '0;
            m_ptr   = 0;
            return;
        end
        free  = !m_valid || rdy;
        win   = -1;
        wtype = 1'b0;
        for (int j = 0; j < N; j++) begin
            int k;
            k = (m_ptr + j) % N;
            if (win < 0 && m_slot[k]) win = k;
        end
        if (win >= 0) wtype = m_type[win];
        nlost = clr ? '0 : m_lost;
        for (int i = 0; i < N; i++) begin
            bit r;
            bit f;
            bit granted;
            r = sw[i] && !m_prev[i];
            f = !sw[i] && m_prev[i];
            granted = free && (win == i);
            if (r || f) begin
                if (!m_slot[i] || granted) begin
                    m_slot[i] = 1'b1;
                    m_type[i] = r;
                end else begin
                    nlost[i] = 1'b1;
                end
            end else if (granted) begin
                m_slot[i] = 1'b0;
            end
            m_prev[i] = sw[i];
        end
        m_lost = nlost;
        if (free) begin
            if (win >= 0) begin
                m_valid = 1'b1;
                m_idx   = win;
                m_press = wtype;
                m_ptr   = (win + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_outputs();
        check("valid", {31'b0, valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("index", {30'b0, idx}, m_idx);
            check("press", {31'b0, press}, {31'b0, m_press});
        end
        check("lost", {28'b0, lost}, {28'b0, m_lost});
    endtask

    // Inputs are changed away from the rising edge; model advances with the DUT.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset(input logic [N-1:0] level);
        rst = 1'b1;
        sw  = level;
        cyc();
        rst = 1'b0;
    endtask

    int cnt0;
    int cnt1;

    initial begin
        rst = 1'b1;
        sw  = 4'b0101;
        rdy = 1'b0;
        clr = 1'b0;

        // Levels held through reset produce no events.
        cyc();
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_lost", {28'b0, lost}, 32'd0);
        cyc();
        rst = 1'b0;
        rdy = 1'b1;
        repeat (20) cyc();
        check("hold_valid", {31'b0, valid}, 32'd0);
        check("hold_lost", {28'b0, lost}, 32'd0);

        // Single press then release on switch 2, two-cycle latency.
        do_reset(4'b0000);
        repeat (3) cyc();
        sw = 4'b0100;
        cyc();
        check("lat_t1", {31'b0, valid}, 32'd0);
        cyc();
        check("press_valid", {31'b0, valid}, 32'd1);
        check("press_idx", {30'b0, idx}, 32'd2);
        check("press_type", {31'b0, press}, 32'd1);
        cyc();
        check("press_once", {31'b0, valid}, 32'd0);
        sw = 4'b0000;
        cyc();
        cyc();
        check("rel_idx", {30'b0, idx}, 32'd2);
        check("rel_type", {31'b0, press}, 32'd0);
        cyc();

        // All four rise together from pointer 0: grants 0,1,2,3 back-to-back.
        do_reset(4'b0000);
        sw = 4'b1111;
        cyc();
        for (int k = 0; k < N; k++) begin
            cyc();
            check("burst_valid", {31'b0, valid}, 32'd1);
            check("burst_idx", {30'b0, idx}, k);
            check("burst_type", {31'b0, press}, 32'd1);
        end
        cyc();
        check("burst_done", {31'b0, valid}, 32'd0);

        // Stall: switch 1 presented, switch 3 rise kept, fall and rise dropped.
        do_reset(4'b0000);
        rdy = 1'b0;
        sw  = 4'b0010;
        cyc();
        cyc();
        check("stall_idx", {30'b0, idx}, 32'd1);
        sw = 4'b1010; cyc();
        sw = 4'b0010; cyc();
        sw = 4'b1010; cyc();
        check("stall_lost", {28'b0, lost}, 32'h8);
        check("stall_hold", {30'b0, idx}, 32'd1);
        rdy = 1'b1;
        cyc();
        check("unstall_idx", {30'b0, idx}, 32'd3);
        check("unstall_type", {31'b0, press}, 32'd1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("lost_clear", {28'b0, lost}, 32'd0);
        repeat (3) cyc();

        // Fairness between two constantly re-armed switches.
        do_reset(4'b0000);
        cnt0 = 0;
        cnt1 = 0;
        for (int c = 0; c < 24; c++) begin
            sw = (c % 2 == 0) ? 4'b0011 : 4'b0000;
            cyc();
            if (valid && idx == 2'd0) cnt0++;
            if (valid && idx == 2'd1) cnt1++;
        end
        check("fair_both", {31'b0, (cnt0 > 0 && cnt1 > 0)}, 32'd1);
        check("fair_bal", {31'b0, (cnt0 - cnt1 <= 1 && cnt1 - cnt0 <= 1)}, 32'd1);
        sw = 4'b0000;
        repeat (6) cyc();

        // Reset mid-handshake discards presented and pending events.
        do_reset(4'b0000);
        rdy = 1'b0;
        sw  = 4'b0111;
        repeat (3) cyc();
        check("pre_rst_valid", {31'b0, valid}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_valid", {31'b0, valid}, 32'd0);
        rdy = 1'b1;
        repeat (6) cyc();
        check("post_rst_quiet", {31'b0, valid}, 32'd0);

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) sw[i] = ~sw[i];
            end
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
        clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
